// File: rtl/rx_cmd_parser_pkg.sv
// Opcode table, payload-length lookup and state encoding shared by rx_cmd_parser.
// RX_CMD_PARSER_CHECKSUM_EN adds the trailing-checksum states.
package rx_cmd_parser_pkg;

    localparam int unsigned CODE_W    = 8;
    localparam int unsigned PAYLOAD_W = 16;

    localparam logic [CODE_W-1:0] CMD_SET_REGISTER    = 8'h10;
    localparam logic [CODE_W-1:0] CMD_RW_ADCONF       = 8'h11;
    localparam logic [CODE_W-1:0] CMD_TOGGLE_MCP      = 8'h20;
    localparam logic [CODE_W-1:0] CMD_TOGGLE_READ_CCD = 8'h21;
    localparam logic [CODE_W-1:0] CMD_OPEN_SHUTTER    = 8'h22;
    localparam logic [CODE_W-1:0] CMD_CLOSE_SHUTTER   = 8'h23;
    localparam logic [CODE_W-1:0] CMD_RESET           = 8'h2F;

    typedef struct packed {
        logic [CODE_W-1:0]    code;
        logic [PAYLOAD_W-1:0] payload;
    } cmd_t;

    typedef struct packed {
        logic       known;
        logic [1:0] len;
    } cmd_info_t;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_GAP_OP = 4'd1,
        ST_B1     = 4'd2,
        ST_GAP1   = 4'd3,
        ST_B2     = 4'd4,
        ST_GAP2   = 4'd5,
        ST_EMIT   = 4'd6
`ifdef RX_CMD_PARSER_CHECKSUM_EN
        ,
        ST_CK     = 4'd7,
        ST_GAP_CK = 4'd8
`endif
    } state_t;

    // Payload length in bytes for a known opcode; known=0 flags an unknown code.
    function automatic cmd_info_t cmd_lookup(input logic [CODE_W-1:0] code);
        cmd_info_t info;
        info.known = 1'b0;
        info.len   = 2'd0;
        case (code)
            CMD_SET_REGISTER, CMD_RW_ADCONF: begin
                info.known = 1'b1;
                info.len   = 2'd2;
            end
            CMD_TOGGLE_MCP, CMD_TOGGLE_READ_CCD, CMD_OPEN_SHUTTER,
            CMD_CLOSE_SHUTTER, CMD_RESET: begin
                info.known = 1'b1;
                info.len   = 2'd0;
            end
            default: begin
                info.known = 1'b0;
                info.len   = 2'd0;
            end
        endcase
        return info;
    endfunction

endpackage

// File: rtl/rx_cmd_parser_timeout.sv
// rx_timeout: saturating inter-byte idle counter with clear/run controls and a
// terminal-count flag at TIMEOUT_CYCLES-1.
module rx_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TO_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tc_c
);

    localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_count;

    // Holds at the terminal value instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run && (r_count != TC_VAL)) begin
            r_count <= r_count + TO_W'(1);
        end
    end

    assign o_tc_c = (r_count == TC_VAL);

endmodule

// File: rtl/rx_cmd_parser.sv
// Pops opcode/payload bytes from the rx FIFO, validates the opcode and presents one
// command on a valid/ready handshake. RX_CMD_PARSER_CHECKSUM_EN adds a trailing XOR byte.
module rx_cmd_parser
    import rx_cmd_parser_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TO_W           = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CODE_W-1:0]    rx_rdata,
    input  logic                 rx_rempty,
    output logic                 rx_rinc,
    input  logic                 ft_busy,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [CODE_W-1:0]    cmd_code,
    output logic [PAYLOAD_W-1:0] cmd_payload,
    output logic                 err_unknown,
    output logic                 err_timeout,
    output logic                 err_checksum,
    output logic                 busy
);

    state_t    r_state;
    state_t    w_state_nxt;
    cmd_t      r_cmd;
    cmd_info_t w_info;

    logic w_payload_wait;
    logic w_fetch;
    logic w_pop;
    logic w_tc;
    logic w_err_unknown;
    logic w_err_timeout;
    logic r_valid;
    logic r_busy;
    logic r_err_unknown;
    logic r_err_timeout;

`ifdef RX_CMD_PARSER_CHECKSUM_EN
    logic [CODE_W-1:0] r_ck;
    logic [CODE_W-1:0] w_ck_calc;
    logic              w_err_checksum;
    logic              r_err_checksum;
`endif

    always_comb begin
        w_payload_wait = (r_state == ST_B1) || (r_state == ST_B2);
`ifdef RX_CMD_PARSER_CHECKSUM_EN
        if (r_state == ST_CK) begin
            w_payload_wait = 1'b1;
        end
`endif
    end

    // Reset holds the pop low so no FIFO byte is lost while the parser restarts.
    assign w_fetch = w_payload_wait || (r_state == ST_IDLE);
    assign w_pop   = w_fetch && !rx_rempty && !ft_busy && !rst;
    assign rx_rinc = w_pop;
    assign w_info  = cmd_lookup(r_cmd.code);

    rx_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .i_clear (!w_payload_wait || w_pop),
        .i_run   (w_payload_wait && !w_pop),
        .o_tc_c  (w_tc)
    );

`ifdef RX_CMD_PARSER_CHECKSUM_EN
    assign w_ck_calc = r_cmd.code ^ r_cmd.payload[15:8] ^ r_cmd.payload[7:0];
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_err_unknown = 1'b0;
        w_err_timeout = 1'b0;
`ifdef RX_CMD_PARSER_CHECKSUM_EN
        w_err_checksum = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_pop) w_state_nxt = ST_GAP_OP;
            end
            ST_GAP_OP: begin
                if (!w_info.known) begin
                    w_err_unknown = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (w_info.len == 2'd0) begin
`ifdef RX_CMD_PARSER_CHECKSUM_EN
                    w_state_nxt = ST_CK;
`else
                    w_state_nxt = ST_EMIT;
`endif
                end else begin
                    w_state_nxt = ST_B1;
                end
            end
            ST_B1: begin
                if (w_pop) begin
                    w_state_nxt = ST_GAP1;
                end else if (w_tc) begin
                    w_err_timeout = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_GAP1: w_state_nxt = ST_B2;
            ST_B2: begin
                if (w_pop) begin
                    w_state_nxt = ST_GAP2;
                end else if (w_tc) begin
                    w_err_timeout = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_GAP2: begin
`ifdef RX_CMD_PARSER_CHECKSUM_EN
                w_state_nxt = ST_CK;
`else
                w_state_nxt = ST_EMIT;
`endif
            end
`ifdef RX_CMD_PARSER_CHECKSUM_EN
            ST_CK: begin
                if (w_pop) begin
                    w_state_nxt = ST_GAP_CK;
                end else if (w_tc) begin
                    w_err_timeout = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_GAP_CK: begin
                if (r_ck != w_ck_calc) begin
                    w_err_checksum = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_state_nxt = ST_EMIT;
                end
            end
`endif
            ST_EMIT: begin
                if (cmd_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_err_unknown <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_valid       <= (w_state_nxt == ST_EMIT);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_err_unknown <= w_err_unknown;
            r_err_timeout <= w_err_timeout;
        end
    end

    // A new opcode clears the payload so zero-payload commands present 16'h0000.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= '0;
        end else if (w_pop) begin
            unique case (r_state)
                ST_IDLE: begin
                    r_cmd.code    <= rx_rdata;
                    r_cmd.payload <= '0;
                end
                ST_B1:   r_cmd.payload[15:8] <= rx_rdata;
                ST_B2:   r_cmd.payload[7:0]  <= rx_rdata;
                default: ;
            endcase
        end
    end

`ifdef RX_CMD_PARSER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ck           <= '0;
            r_err_checksum <= 1'b0;
        end else begin
            r_err_checksum <= w_err_checksum;
            if (w_pop && (r_state == ST_CK)) r_ck <= rx_rdata;
        end
    end

    assign err_checksum = r_err_checksum;
`else
    assign err_checksum = 1'b0;
`endif

    assign cmd_valid   = r_valid;
    assign cmd_code    = r_cmd.code;
    assign cmd_payload = r_cmd.payload;
    assign err_unknown = r_err_unknown;
    assign err_timeout = r_err_timeout;
    assign busy        = r_busy;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Bench for rx_cmd_parser: FIFO model, expected-event scoreboard built from the
// pushed byte stream, directed corner cases and a randomized command mix.
module tb_rx_cmd_parser;
    import rx_cmd_parser_pkg::*;

    localparam int unsigned T_CYC = 16;
    localparam int unsigned T_W   = 5;
`ifdef RX_CMD_PARSER_CHECKSUM_EN
    localparam int CK_BYTES = 1;
`else
    localparam int CK_BYTES = 0;
`endif
    localparam int EV_CMD = 0;
    localparam int EV_UNK = 1;
    localparam int EV_TO  = 2;
    localparam int EV_CK  = 3;

    typedef struct {
        int          kind;
        logic [7:0]  code;
        logic [15:0] payload;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_rdata;
    logic        rx_rempty;
    logic        rx_rinc;
    logic        ft_busy;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_payload;
    logic        err_unknown;
    logic        err_timeout;
    logic        err_checksum;
    logic        busy;

    logic [7:0] fifo[$];
    ev_t        exp_q[$];

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int last_pop_cyc = -100;
    int n_pops = 0;
    int n_valid_cyc = 0;
    int n_unk = 0;
    int to_cyc = -1;
    logic        s_rinc = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [7:0]  prev_code = '0;
    logic [15:0] prev_payload = '0;

    always #5 clk = ~clk;

    rx_cmd_parser #(
        .TIMEOUT_CYCLES (T_CYC),
        .TO_W           (T_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_rdata     (rx_rdata),
        .rx_rempty    (rx_rempty),
        .rx_rinc      (rx_rinc),
        .ft_busy      (ft_busy),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_code     (cmd_code),
        .cmd_payload  (cmd_payload),
        .err_unknown  (err_unknown),
        .err_timeout  (err_timeout),
        .err_checksum (err_checksum),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Command table as a plain list: 2 = two payload bytes, 0 = none, -1 = unknown.
    function automatic int ref_len(input logic [7:0] c);
        if (c == CMD_SET_REGISTER || c == CMD_RW_ADCONF) return 2;
        if (c == CMD_TOGGLE_MCP || c == CMD_TOGGLE_READ_CCD || c == CMD_OPEN_SHUTTER ||
            c == CMD_CLOSE_SHUTTER || c == CMD_RESET) return 0;
        return -1;
    endfunction

    task automatic drive_fifo();
        rx_rempty = (fifo.size() == 0);
        rx_rdata  = (fifo.size() == 0) ? 8'h00 : fifo[0];
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        drive_fifo();
    endtask

    task automatic push_cmd(input logic [7:0] code, input logic [15:0] pl, input bit corrupt);
        ev_t e;
        int  len;
        len       = ref_len(code);
        e.kind    = (corrupt && CK_BYTES == 1) ? EV_CK : EV_CMD;
        e.code    = code;
        e.payload = (len == 2) ? pl : 16'h0000;
        push_byte(code);
        if (len == 2) begin
            push_byte(pl[15:8]);
            push_byte(pl[7:0]);
        end
`ifdef RX_CMD_PARSER_CHECKSUM_EN
        begin
            logic [7:0] ck;
            ck = code ^ e.payload[15:8] ^ e.payload[7:0];
            if (corrupt) ck = ck ^ 8'h5A;
            push_byte(ck);
        end
`endif
        exp_q.push_back(e);
    endtask

    task automatic push_unknown(input logic [7:0] b);
        ev_t e;
        e.kind    = EV_UNK;
        e.code    = b;
        e.payload = 16'h0000;
        push_byte(b);
        exp_q.push_back(e);
    endtask

    task automatic match_event(input string tag, input int kind);
        ev_t e;
        check_eq({tag, "_expected"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({tag, "_kind"}, 32'(kind), 32'(e.kind));
            check_eq({tag, "_code"}, 32'(cmd_code), 32'(e.code));
            if (kind == EV_CMD) check_eq({tag, "_payload"}, 32'(cmd_payload), 32'(e.payload));
        end
    endtask

    // One clock: observe on the falling edge, let the FIFO pop after the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        s_rinc = rx_rinc;
        if (rx_rinc) begin
            check_eq("pop_allowed", 32'({rx_rempty, ft_busy}), 32'd0);
            check_eq("pop_spacing", 32'((cyc - last_pop_cyc) >= 2), 32'd1);
            check_eq("pop_in_emit", 32'(cmd_valid), 32'd0);
            last_pop_cyc = cyc;
            n_pops++;
        end
        if (prev_valid && !prev_ready) begin
            check_eq("hold_valid", 32'(cmd_valid), 32'd1);
            check_eq("hold_code", 32'(cmd_code), 32'(prev_code));
            check_eq("hold_payload", 32'(cmd_payload), 32'(prev_payload));
        end
        if (cmd_valid && !prev_valid) check_eq("valid_latency", 32'(cyc - last_pop_cyc), 32'd2);
        if (cmd_valid) begin
            n_valid_cyc++;
            check_eq("busy_in_emit", 32'(busy), 32'd1);
        end
        if (cmd_valid && cmd_ready) match_event("cmd", EV_CMD);
        if (err_unknown) begin
            n_unk++;
            match_event("unknown", EV_UNK);
        end
        if (err_timeout) begin
            to_cyc = cyc;
            match_event("timeout", EV_TO);
        end
        if (err_checksum) match_event("checksum", EV_CK);
        prev_valid   = cmd_valid;
        prev_ready   = cmd_ready;
        prev_code    = cmd_code;
        prev_payload = cmd_payload;
        @(posedge clk);
        #1;
        if (s_rinc) void'(fifo.pop_front());
        drive_fifo();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_pops(input int n);
        int target;
        target = n_pops + n;
        for (int k = 0; k < 200 && n_pops < target; k++) tick();
        check_eq("wait_pops", 32'(n_pops >= target), 32'd1);
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 200 && !cmd_valid; k++) tick();
        check_eq("wait_valid", 32'(cmd_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int v0;
        int u0;
        int pc;
        ev_t e;

        rst       = 1'b1;
        ft_busy   = 1'b0;
        cmd_ready = 1'b1;
        drive_fifo();
        run(3);
        check_eq("rst_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_code", 32'(cmd_code), 32'd0);
        check_eq("rst_payload", 32'(cmd_payload), 32'd0);
        check_eq("rst_errs", 32'({err_unknown, err_timeout, err_checksum}), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Single zero-payload command.
        p0 = n_pops; v0 = n_valid_cyc;
        push_cmd(CMD_TOGGLE_MCP, 16'h0000, 1'b0);
        run(20);
        check_eq("mcp_pops", 32'(n_pops - p0), 32'(1 + CK_BYTES));
        check_eq("mcp_valid_cycles", 32'(n_valid_cyc - v0), 32'd1);

        // Payload command held under backpressure with more data queued behind it.
        cmd_ready = 1'b0;
        push_cmd(CMD_SET_REGISTER, 16'h0255, 1'b0);
        push_cmd(CMD_TOGGLE_MCP, 16'h0000, 1'b0);
        wait_valid();
        check_eq("setreg_code", 32'(cmd_code), 32'(CMD_SET_REGISTER));
        check_eq("setreg_payload", 32'(cmd_payload), 32'h0255);
        p0 = n_pops;
        run(10);
        check_eq("hold_no_pops", 32'(n_pops - p0), 32'd0);
        cmd_ready = 1'b1;
        run(30);

        // Unknown opcode, then a normal command.
        u0 = n_unk; v0 = n_valid_cyc;
        push_unknown(8'hEE);
        push_cmd(CMD_OPEN_SHUTTER, 16'h0000, 1'b0);
        run(30);
        check_eq("unk_pulses", 32'(n_unk - u0), 32'd1);
        check_eq("unk_then_valid", 32'(n_valid_cyc - v0), 32'd1);

        // Byte2 arrives exactly on the terminal-count cycle: the pop wins.
        push_byte(CMD_RW_ADCONF);
        push_byte(8'h12);
        wait_pops(2);
        run(T_CYC);
        push_byte(8'h34);
`ifdef RX_CMD_PARSER_CHECKSUM_EN
        push_byte(CMD_RW_ADCONF ^ 8'h12 ^ 8'h34);
`endif
        e.kind = EV_CMD; e.code = CMD_RW_ADCONF; e.payload = 16'h1234;
        exp_q.push_back(e);
        run(30);

        // One cycle later: timeout, and the late byte becomes an opcode.
        push_byte(CMD_RW_ADCONF);
        push_byte(8'h12);
        e.kind = EV_TO; e.code = CMD_RW_ADCONF; e.payload = 16'h0000;
        exp_q.push_back(e);
        wait_pops(2);
        pc = last_pop_cyc;
        to_cyc = -1;
        run(T_CYC + 1);
        push_unknown(8'h34);
        run(30);
        check_eq("timeout_latency", 32'(to_cyc - pc), 32'(T_CYC + 2));

        // FIFO has data but the FT245 side is busy.
        ft_busy = 1'b1;
        push_cmd(CMD_CLOSE_SHUTTER, 16'h0000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("ftbusy_no_pop", 32'(s_rinc), 32'd0);
        end
        ft_busy = 1'b0;
        tick();
        check_eq("pop_after_ftbusy", 32'(s_rinc), 32'd1);
        run(20);

        // Reset while waiting for byte2 drops the partial command.
        push_byte(CMD_SET_REGISTER);
        push_byte(8'hAB);
        wait_pops(2);
        tick();
        check_eq("in_b2_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_b2_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_b2_busy", 32'(busy), 32'd0);
        push_unknown(8'hCD);
        push_cmd(CMD_TOGGLE_READ_CCD, 16'h0000, 1'b0);
        run(30);

`ifdef RX_CMD_PARSER_CHECKSUM_EN
        v0 = n_valid_cyc;
        push_cmd(CMD_SET_REGISTER, 16'h0102, 1'b1);
        run(30);
        check_eq("bad_ck_no_valid", 32'(n_valid_cyc - v0), 32'd0);
`endif

        // Randomized command mix with random backpressure and FT245 stalls.
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                logic [7:0] b;
                do b = 8'($urandom); while (ref_len(b) >= 0);
                push_unknown(b);
            end else begin
                logic [7:0] codes [7];
                codes = '{CMD_SET_REGISTER, CMD_RW_ADCONF, CMD_TOGGLE_MCP, CMD_TOGGLE_READ_CCD,
                          CMD_OPEN_SHUTTER, CMD_CLOSE_SHUTTER, CMD_RESET};
                push_cmd(codes[$urandom_range(0, 6)], 16'($urandom), $urandom_range(0, 7) == 0);
            end
            repeat ($urandom_range(0, 6)) begin
                cmd_ready = ($urandom_range(0, 3) != 0);
                ft_busy   = ($urandom_range(0, 4) == 0);
                tick();
            end
        end
        cmd_ready = 1'b1;
        ft_busy   = 1'b0;
        for (int k = 0; k < 3000 && !(fifo.size() == 0 && exp_q.size() == 0 && !busy); k++) tick();
        run(5);
        check_eq("drain_events_left", 32'(exp_q.size()), 32'd0);
        check_eq("drain_fifo_left", 32'(fifo.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
